// File: rtl/shift_left_arbiter_if.sv
// shift_left_arbiter_if: requester handshakes and shift-unit bus for shift_left_arbiter
interface shift_left_arbiter_if #(parameter int WIDTH = 4);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [1:0]       req0_sl;
  logic             req0_ready;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [1:0]       req1_sl;
  logic             req1_ready;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_data;
  logic             rsp1_ready;
  logic [WIDTH-1:0] sh_a;
  logic [1:0]       sh_sl;
  logic [WIDTH-1:0] sh_y;
  logic             busy;
  modport master (
    output req0_valid, req0_a, req0_sl, rsp0_ready,
    output req1_valid, req1_a, req1_sl, rsp1_ready, sh_y,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data, sh_a, sh_sl, busy
  );
  modport slave (
    input  req0_valid, req0_a, req0_sl, rsp0_ready,
    input  req1_valid, req1_a, req1_sl, rsp1_ready, sh_y,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data, sh_a, sh_sl, busy
  );
endinterface

// File: rtl/shift_left_arbiter.sv
// shift_left_arbiter: shares one left-shift unit between two requesters; SHIFT_ARB_FIXED_PRIO_EN selects fixed priority (default round-robin)
module shift_left_arbiter #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  shift_left_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  state_t           r_state;
  logic             r_owner;
  logic             r_last;
  logic [WIDTH-1:0] r_op_a;
  logic [1:0]       r_op_sl;
  logic [WIDTH-1:0] r_rsp0_data;
  logic [WIDTH-1:0] r_rsp1_data;
  logic             w_idle;
  logic             w_pick1;
  logic             w_rsp_ready;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign w_pick1 = bus.req1_valid & ~bus.req0_valid;
`else
  assign w_pick1 = bus.req1_valid & (~bus.req0_valid | ~r_last);
`endif
  assign w_idle         = rst_n & (r_state == IDLE);
  assign bus.req0_ready = w_idle & bus.req0_valid & ~w_pick1;
  assign bus.req1_ready = w_idle & w_pick1;
  assign bus.rsp0_valid = (r_state == RESP) & ~r_owner;
  assign bus.rsp1_valid = (r_state == RESP) & r_owner;
  assign bus.rsp0_data  = r_rsp0_data;
  assign bus.rsp1_data  = r_rsp1_data;
  assign bus.sh_a       = r_op_a;
  assign bus.sh_sl      = r_op_sl;
  assign bus.busy       = r_state != IDLE;
  assign w_rsp_ready    = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
  // accept -> shift -> hold response until the owner takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_op_a      <= '0;
      r_op_sl     <= '0;
      r_rsp0_data <= '0;
      r_rsp1_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req0_ready | bus.req1_ready) begin
          r_op_a  <= w_pick1 ? bus.req1_a : bus.req0_a;
          r_op_sl <= w_pick1 ? bus.req1_sl : bus.req0_sl;
          r_owner <= w_pick1;
          r_last  <= w_pick1;
          r_state <= EXEC;
        end
        EXEC: begin
          if (r_owner) r_rsp1_data <= bus.sh_y;
          else r_rsp0_data <= bus.sh_y;
          r_state <= RESP;
        end
        RESP: if (w_rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
